uart_rx: RTL and testbench

Asynchronous serial receiver: the receive-side counterpart to `uart_tx`, sharing the `baud_gen` oversample tick. It synchronizes the `rx` line, detects and validates start bits, and samples data, optional parity and stop bits at mid-bit. Each received byte is presented on a one-entry valid/ready output register with parity, framing and overrun status. It sits between the pad-side `rx` pin and the byte consumer (FIFO or command parser).

---
 rtl/uart_rx.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Asynchronous serial receiver: oversampled start detection, mid-bit data/parity/stop
// sampling, and a one-entry valid/ready output register with parity/framing/overrun status.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 oversample_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic                 rx_meta, rx_s;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 pen_q, pen_d;
  logic                 podd_q, podd_d;
  logic                 perr_q, perr_d;
  logic                 out_valid_d, parity_err_d, frame_err_d, overrun_d, busy_d;
  logic [DATA_BITS-1:0] out_data_d;
  logic                 deliver;

  // Two-flop synchronizer; idle-high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      pen_q      <= 1'b0;
      podd_q     <= 1'b0;
      perr_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      pen_q      <= pen_d;
      podd_q     <= podd_d;
      perr_q     <= perr_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      parity_err <= parity_err_d;
      frame_err  <= frame_err_d;
      overrun    <= overrun_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    pen_d        = pen_q;
    podd_d       = podd_q;
    perr_d       = perr_q;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    parity_err_d = parity_err;
    frame_err_d  = frame_err;
    overrun_d    = overrun;
    deliver      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (oversample_tick && !rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (oversample_tick) begin
          if (cnt_q == CNT_MID) begin
            cnt_d = '0;
            if (!rx_s) begin
              state_d = S_DATA;
              idx_d   = '0;
              pen_d   = parity_en;
              podd_d  = parity_odd;
              perr_d  = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (oversample_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = pen_q ? S_PARITY : S_STOP;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (oversample_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            perr_d  = ((^shreg_q) ^ rx_s) != podd_q;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_STOP: begin
        if (oversample_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            deliver = 1'b1;
            state_d = rx_s ? S_IDLE : S_BREAK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Output register: handshake empties it; a frame loads only if it is free this cycle.
    if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (deliver) begin
      if (!out_valid || out_ready) begin
        out_valid_d  = 1'b1;
        out_data_d   = shreg_q;
        parity_err_d = perr_q;
        frame_err_d  = !rx_s;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized + directed bench for uart_rx; frames are bit-banged on rx and a
// scoreboard queue of expected bytes is drained by an independent monitor.
module tb_uart_rx;
  localparam int OS = 16;
  localparam int DB = 8;
  localparam int TD = 4;
  localparam int BC = OS * TD;
  localparam int STOP_TICK = 1 + OS / 2 + OS * (DB + 2);

  logic          clk = 1'b0;
  logic          reset, oversample_tick, rx, parity_en, parity_odd;
  logic          out_valid, out_ready, parity_err, frame_err, overrun, busy;
  logic [DB-1:0] out_data;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  typedef struct packed {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .oversample_tick(oversample_tick), .rx(rx),
    .parity_en(parity_en), .parity_odd(parity_odd), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign oversample_tick = (cyc % TD == 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted byte must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=%0h required=none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_byte{data,perr,ferr}", 32'({out_data, parity_err, frame_err}), 32'(mon_e));
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BC) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic pe, input logic podd,
                            input logic bad_par, input logic bad_stop, input logic push,
                            input logic scramble);
    exp_t e;
    parity_en  = pe;
    parity_odd = podd;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) begin
      if (scramble && i == DB / 2) begin
        parity_en  = 1'($urandom);
        parity_odd = 1'($urandom);
      end
      send_bit(d[i]);
    end
    if (pe) send_bit((^d) ^ podd ^ bad_par);
    e.d  = d;
    e.pe = pe & bad_par;
    e.fe = bad_stop;
    if (push) exp_q.push_back(e);
    send_bit(!bad_stop);
  endtask

  initial begin
    logic [DB-1:0] rd;
    logic rpe, rodd, rbp, rbs;
    int c0, t;

    reset = 1'b0; rx = 1'b1; out_ready = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_parity_err", 32'(parity_err), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    repeat (2 * BC) @(negedge clk);

    // Even parity, four frames back-to-back.
    send_frame(8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (BC) @(negedge clk);

    // Inverted parity bit, then a parity-less 10-bit frame.
    send_frame(8'h41, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (BC) @(negedge clk);

    // Short low glitch on idle line must be rejected.
    rx = 1'b0;
    repeat (3 * TD) @(negedge clk);
    rx = 1'b1;
    repeat (BC) @(negedge clk);
    chk("glitch_busy", 32'(busy), 0);
    chk("glitch_out_valid", 32'(out_valid), 0);
    chk("glitch_flags", 32'({parity_err, frame_err, overrun}), 0);

    // Framing error followed by a held-low line (break).
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (BC + BC / 2) @(negedge clk);
    chk("break_busy", 32'(busy), 1);
    chk("break_frame_err", 32'(frame_err), 1);
    repeat (BC + BC / 2) @(negedge clk);
    chk("break_no_byte", 32'(out_valid), 0);
    rx = 1'b1;
    repeat (BC / 4) @(negedge clk);
    chk("break_exit_busy", 32'(busy), 0);
    repeat (BC) @(negedge clk);

    // Overrun: second frame dropped while the first is held.
    set_ready(1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (BC / 2) @(negedge clk);
    chk("ovr_valid", 32'(out_valid), 1);
    chk("ovr_data", 32'(out_data), 32'h11);
    chk("ovr_flag", 32'(overrun), 1);
    set_ready(1'b1);
    set_ready(1'b0);
    chk("ovr_clear_valid", 32'(out_valid), 0);
    chk("ovr_clear_flag", 32'(overrun), 0);

    // Handshake lands on the exact cycle the next frame is delivered.
    send_frame(8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (BC) @(negedge clk);
    do @(negedge clk); while (cyc % TD != 0);
    c0 = cyc;
    fork
      send_frame(8'h5E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        wait (cyc == c0 + STOP_TICK * TD);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
      end
    join
    chk("same_cycle_overrun", 32'(overrun), 0);
    chk("same_cycle_valid", 32'(out_valid), 1);
    chk("same_cycle_data", 32'(out_data), 32'h5E);
    set_ready(1'b1);
    repeat (BC) @(negedge clk);

    // Reset mid-way through bit 3 of 0x3C, then a clean 0xC3.
    parity_en = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b1;
    repeat (BC / 2) @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_flags", 32'({parity_err, frame_err, overrun}), 0);
    chk("midrst_busy", 32'(busy), 0);
    reset = 1'b1;
    repeat (2 * BC) @(negedge clk);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (BC) @(negedge clk);
    chk("midrst_queue_empty", 32'(exp_q.size()), 0);

    // Randomized frames: parity mode, errors, gaps and mid-frame mode changes.
    for (int f = 0; f < 20; f++) begin
      rd   = DB'($urandom);
      rpe  = 1'($urandom);
      rodd = 1'($urandom);
      rbp  = ($urandom_range(0, 5) == 0);
      rbs  = ($urandom_range(0, 7) == 0);
      send_frame(rd, rpe, rodd, rbp, rbs, 1'b1, 1'b1);
      if (rbs) begin
        rx = 1'b0;
        repeat (BC * $urandom_range(0, 2)) @(negedge clk);
        rx = 1'b1;
        repeat (BC) @(negedge clk);
      end else begin
        repeat (BC * $urandom_range(0, 2)) @(negedge clk);
      end
    end

    t = 0;
    while (exp_q.size() != 0 && t < 4 * BC) begin
      @(negedge clk);
      t++;
    end
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    chk("final_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
